// File: rtl/read_sweep_pkg.sv
// -----------------------------------------------------------------------------
// read_sweep_pkg
// Shared types and constants for the read-latency sweep sequencer.
//   state_e    : sequencer FSM states (IDLE, ISSUE, WAIT, ACCUM, DONE)
//   SEL_*      : result select codes carried on m_input_select
//   LAT_MAX    : saturation value of the per-probe latency counter
//   MIN_INIT   : value the running minimum starts from
//   sat_inc()  : 32-bit increment that sticks at LAT_MAX
// -----------------------------------------------------------------------------
package read_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACCUM = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0] SEL_SUM = 2'd0;
    localparam logic [1:0] SEL_MIN = 2'd1;
    localparam logic [1:0] SEL_MAX = 2'd2;
    localparam logic [1:0] SEL_ERR = 2'd3;

    localparam logic [31:0] LAT_MAX  = 32'hFFFF_FFFF;
    localparam logic [31:0] MIN_INIT = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == LAT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/latency_stats.sv
// -----------------------------------------------------------------------------
// latency_stats
// Running min / max / sum / mismatch-count over the probe latencies of one
// sweep.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clear_i       : restart statistics (start of a new invocation)
//   acc_i         : fold lat_i / mismatch_i into the statistics this cycle
//   lat_i         : measured latency of the probe being accumulated
//   mismatch_i    : returned word differed from the expected word
//   min_o, max_o  : running minimum / maximum latency
//   sum_o         : latency sum saturated to 32 bits
//   errs_o        : number of mismatching probes
// -----------------------------------------------------------------------------
module latency_stats
    import read_sweep_pkg::*;
#(
    parameter int SUM_W = 40
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        acc_i,
    input  logic [31:0] lat_i,
    input  logic        mismatch_i,
    output logic [31:0] min_o,
    output logic [31:0] max_o,
    output logic [31:0] sum_o,
    output logic [31:0] errs_o
);

    logic [31:0]      min_q, min_d;
    logic [31:0]      max_q, max_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [31:0]      errs_q, errs_d;
    logic [SUM_W:0]   sum_ext;

    // One extra bit catches accumulator overflow; the sum then sticks at all-ones.
    assign sum_ext = {1'b0, sum_q} + (SUM_W+1)'(lat_i);

    always_comb begin
        min_d  = min_q;
        max_d  = max_q;
        sum_d  = sum_q;
        errs_d = errs_q;
        if (clear_i) begin
            min_d  = MIN_INIT;
            max_d  = '0;
            sum_d  = '0;
            errs_d = '0;
        end else if (acc_i) begin
            if (lat_i < min_q) min_d = lat_i;
            if (lat_i > max_q) max_d = lat_i;
            sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            if (mismatch_i) errs_d = errs_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            min_q  <= MIN_INIT;
            max_q  <= '0;
            sum_q  <= '0;
            errs_q <= '0;
        end else begin
            min_q  <= min_d;
            max_q  <= max_d;
            sum_q  <= sum_d;
            errs_q <= errs_d;
        end
    end

    assign min_o  = min_q;
    assign max_o  = max_q;
    assign sum_o  = (|sum_q[SUM_W-1:32]) ? 32'hFFFF_FFFF : sum_q[31:0];
    assign errs_o = errs_q;

endmodule

// File: rtl/read_latency_sweep.sv
// -----------------------------------------------------------------------------
// read_latency_sweep
// Issues N strided single-word Avalon-MM reads, one outstanding at a time,
// measures each request-to-data latency, checks the returned word against
// the running expected value (0, stride, 2*stride, ...) and returns one
// selected statistic over an Avalon-ST style invocation handshake.
//
// Invocation side:
//   clock, reset          : clock, synchronous active-high reset
//   m_src_addr            : base byte address (bits [31:0] used)
//   m_input_count         : number of probes N
//   m_input_stride        : element stride between probes
//   m_input_select        : 0 sum, 1 min, 2 max, 3 mismatch count
//   m_valid_in/m_ready_out: invocation accepted when both are high
//   m_valid_out/m_ready_in: result presented in DONE until both are high
//   m_output_value        : selected statistic, 0 outside DONE
// Memory side (Avalon-MM read master):
//   src_address/src_read/src_waitrequest : request, held while stalled
//   src_readdata/src_readdatavalid       : response
//   src_write/src_writedata/src_byteenable/src_burstcount/src_writeack :
//                                          fixed single-word read-only use
//
// Handshake rule: a transfer happens on a rising edge where the producer's
// valid and the consumer's ready are both high; valid, once raised, is held
// with stable data until that edge.
//
// Build option: define READ_SWEEP_TIMEOUT_EN to add a per-probe watchdog of
// TIMEOUT_CYCLES; on expiry the sweep aborts and returns 32'hFFFFFFFF.
// -----------------------------------------------------------------------------
module read_latency_sweep
    import read_sweep_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int SUM_W          = 40,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [63:0]  m_src_addr,
    input  logic [31:0]  m_input_count,
    input  logic [31:0]  m_input_stride,
    input  logic [1:0]   m_input_select,
    output logic [31:0]  m_output_value,
    output logic         m_ready_out,
    input  logic         m_valid_in,
    output logic         m_valid_out,
    input  logic         m_ready_in,
    input  logic [511:0] src_readdata,
    input  logic         src_readdatavalid,
    input  logic         src_waitrequest,
    output logic [31:0]  src_address,
    output logic         src_read,
    output logic         src_write,
    input  logic         src_writeack,
    output logic [511:0] src_writedata,
    output logic [63:0]  src_byteenable,
    output logic [4:0]   src_burstcount
);

    localparam logic [31:0] BYTES = 32'(DATA_W / 8);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [1:0]        sel_q, sel_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       stride_q, stride_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] expect_q, expect_d;
    logic [31:0]       idx_q, idx_d;
    logic [31:0]       lat_q, lat_d;
    logic              mis_q, mis_d;

    logic              start;
    logic              stats_clear, stats_acc;
    logic              read_c;
    logic [31:0]       st_min, st_max, st_sum, st_errs;

`ifdef READ_SWEEP_TIMEOUT_EN
    logic              to_q, to_d;
    logic              timeout_hit;
    assign timeout_hit = (lat_q >= 32'(TIMEOUT_CYCLES));
`endif

    assign start = ready_q & m_valid_in;

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        sel_d       = sel_q;
        count_d     = count_q;
        stride_d    = stride_q;
        addr_d      = addr_q;
        expect_d    = expect_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        mis_d       = mis_q;
        stats_clear = 1'b0;
        stats_acc   = 1'b0;
        read_c      = 1'b0;
`ifdef READ_SWEEP_TIMEOUT_EN
        to_d        = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d       = m_input_select;
                    count_d     = m_input_count;
                    stride_d    = m_input_stride;
                    addr_d      = m_src_addr[31:0];
                    expect_d    = '0;
                    idx_d       = '0;
                    lat_d       = '0;
                    stats_clear = 1'b1;
                    ready_d     = 1'b0;
`ifdef READ_SWEEP_TIMEOUT_EN
                    to_d        = 1'b0;
`endif
                    state_d     = (m_input_count == 32'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // lat is 0 in the first ISSUE cycle and counts stall cycles too.
                read_c = 1'b1;
                lat_d  = sat_inc(lat_q);
                if (!src_waitrequest) state_d = WAIT;
`ifdef READ_SWEEP_TIMEOUT_EN
                if (timeout_hit) begin
                    read_c  = 1'b0;
                    to_d    = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            WAIT: begin
                if (src_readdatavalid) begin
                    // lat_q is held, so ACCUM sees the captured latency.
                    mis_d   = (src_readdata[DATA_W-1:0] != expect_q);
                    state_d = ACCUM;
                end else begin
                    lat_d = sat_inc(lat_q);
`ifdef READ_SWEEP_TIMEOUT_EN
                    if (timeout_hit) begin
                        to_d    = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            ACCUM: begin
                stats_acc = 1'b1;
                idx_d     = idx_q + 32'd1;
                addr_d    = addr_q + stride_q * BYTES;
                expect_d  = expect_q + DATA_W'(stride_q);
                lat_d     = '0;
                state_d   = (idx_d == count_q) ? DONE : ISSUE;
            end
            DONE: begin
                if (m_ready_in) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            sel_q    <= '0;
            count_q  <= '0;
            stride_q <= '0;
            addr_q   <= '0;
            expect_q <= '0;
            idx_q    <= '0;
            lat_q    <= '0;
            mis_q    <= 1'b0;
`ifdef READ_SWEEP_TIMEOUT_EN
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            sel_q    <= sel_d;
            count_q  <= count_d;
            stride_q <= stride_d;
            addr_q   <= addr_d;
            expect_q <= expect_d;
            idx_q    <= idx_d;
            lat_q    <= lat_d;
            mis_q    <= mis_d;
`ifdef READ_SWEEP_TIMEOUT_EN
            to_q     <= to_d;
`endif
        end
    end

    latency_stats #(
        .SUM_W (SUM_W)
    ) u_stats (
        .clk_i      (clock),
        .rst_i      (reset),
        .clear_i    (stats_clear),
        .acc_i      (stats_acc),
        .lat_i      (lat_q),
        .mismatch_i (mis_q),
        .min_o      (st_min),
        .max_o      (st_max),
        .sum_o      (st_sum),
        .errs_o     (st_errs)
    );

    always_comb begin
        m_output_value = '0;
        if (state_q == DONE) begin
            case (sel_q)
                SEL_SUM: m_output_value = st_sum;
                SEL_MIN: m_output_value = (count_q == 32'd0) ? 32'd0 : st_min;
                SEL_MAX: m_output_value = st_max;
                default: m_output_value = st_errs;
            endcase
`ifdef READ_SWEEP_TIMEOUT_EN
            if (to_q) m_output_value = 32'hFFFF_FFFF;
`endif
        end
    end

    assign m_ready_out    = ready_q;
    assign m_valid_out    = (state_q == DONE);
    assign src_read       = read_c;
    assign src_address    = addr_q;
    assign src_write      = 1'b0;
    assign src_writedata  = '0;
    assign src_byteenable = '1;
    assign src_burstcount = 5'd1;

    logic unused_bits;
`ifdef READ_SWEEP_TIMEOUT_EN
    assign unused_bits = ^{m_src_addr[63:32], src_readdata[511:DATA_W], src_writeack};
`else
    assign unused_bits = ^{m_src_addr[63:32], src_readdata[511:DATA_W], src_writeack,
                           32'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_read_latency_sweep.sv
// -----------------------------------------------------------------------------
// tb_read_latency_sweep
// Directed bench for read_latency_sweep. A memory responder returns
// X[j] = j with per-probe latencies (counted from the accepting edge) and
// optional waitrequest stalls; issued addresses are checked against exp_q.
// -----------------------------------------------------------------------------
module tb_read_latency_sweep;
    import read_sweep_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic [63:0]  m_src_addr;
    logic [31:0]  m_input_count;
    logic [31:0]  m_input_stride;
    logic [1:0]   m_input_select;
    logic [31:0]  m_output_value;
    logic         m_ready_out;
    logic         m_valid_in;
    logic         m_valid_out;
    logic         m_ready_in;
    logic [511:0] src_readdata;
    logic         src_readdatavalid;
    logic         src_waitrequest;
    logic [31:0]  src_address;
    logic         src_read;
    logic         src_write;
    logic         src_writeack;
    logic [511:0] src_writedata;
    logic [63:0]  src_byteenable;
    logic [4:0]   src_burstcount;

    read_latency_sweep #(
        .DATA_W         (32),
        .SUM_W          (40),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .m_src_addr        (m_src_addr),
        .m_input_count     (m_input_count),
        .m_input_stride    (m_input_stride),
        .m_input_select    (m_input_select),
        .m_output_value    (m_output_value),
        .m_ready_out       (m_ready_out),
        .m_valid_in        (m_valid_in),
        .m_valid_out       (m_valid_out),
        .m_ready_in        (m_ready_in),
        .src_readdata      (src_readdata),
        .src_readdatavalid (src_readdatavalid),
        .src_waitrequest   (src_waitrequest),
        .src_address       (src_address),
        .src_read          (src_read),
        .src_write         (src_write),
        .src_writeack      (src_writeack),
        .src_writedata     (src_writedata),
        .src_byteenable    (src_byteenable),
        .src_burstcount    (src_burstcount)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    int          lat_tab[4];
    int          stall_tab[4];
    int          probe_n    = 0;
    int          n_acc      = 0;
    int          corrupt_ix = -1;
    bit          drop_resp  = 0;
    logic [31:0] cur_base   = '0;

    initial begin : responder
        int          pend = 0;
        int          stall_left = 0;
        bit          in_req = 0;
        logic [31:0] held_addr = '0;
        logic [31:0] pend_data = '0;
        logic [31:0] ea;
        int          pi;
        int          ix;
        src_waitrequest   = 1'b0;
        src_readdatavalid = 1'b0;
        src_readdata      = '0;
        forever begin
            @(negedge clock);
            src_readdatavalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    src_readdatavalid = 1'b1;
                    src_readdata      = {480'd0, pend_data};
                end
            end
            pi = (probe_n < 4) ? probe_n : 3;
            if (src_read) begin
                if (!in_req) begin
                    in_req     = 1;
                    stall_left = stall_tab[pi];
                    held_addr  = src_address;
                end else begin
                    check("addr_held_in_stall", 64'(src_address), 64'(held_addr));
                end
                if (stall_left > 0) begin
                    src_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    src_waitrequest = 1'b0;
                    in_req = 0;
                    n_acc++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_read", 64'(src_address), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ea = exp_q.pop_front();
                        check("read_addr", 64'(src_address), 64'(ea));
                    end
                    if (!drop_resp) begin
                        ix        = int'((src_address - cur_base) >> 2);
                        pend_data = (ix == corrupt_ix) ? 32'hDEAD : 32'(ix);
                        pend      = lat_tab[pi];
                    end
                    probe_n++;
                end
            end else begin
                src_waitrequest = 1'b0;
                in_req = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_inv(input logic [31:0] base, input logic [31:0] cnt,
                             input logic [31:0] stride, input logic [1:0] sel);
        int w = 0;
        while (!m_ready_out && w < 100) begin
            @(negedge clock);
            w++;
        end
        check("ready_before_start", 64'(m_ready_out), 64'd1);
        m_src_addr     = {32'hABCD_0000, base};
        m_input_count  = cnt;
        m_input_stride = stride;
        m_input_select = sel;
        m_valid_in     = 1'b1;
        @(negedge clock);
        m_valid_in     = 1'b0;
        check("busy_after_start", 64'(m_ready_out), 64'd0);
    endtask

    task automatic wait_valid(input int bound, output int waited);
        waited = 0;
        while (!m_valid_out && waited < bound) begin
            @(negedge clock);
            waited++;
        end
        check("valid_seen", 64'(m_valid_out), 64'd1);
    endtask

    task automatic handshake();
        m_ready_in = 1'b1;
        @(negedge clock);
        m_ready_in = 1'b0;
        check("valid_drop_after_hs", 64'(m_valid_out), 64'd0);
        check("ready_after_hs", 64'(m_ready_out), 64'd1);
        check("value_zero_idle", 64'(m_output_value), 64'd0);
    endtask

    task automatic run_inv(input string tag, input logic [31:0] base, input logic [31:0] cnt,
                           input logic [31:0] stride, input logic [1:0] sel,
                           input logic [31:0] exp_val);
        int waited;
        for (int j = 0; j < int'(cnt); j++) exp_q.push_back(base + 32'(j) * stride * 32'd4);
        cur_base = base;
        probe_n  = 0;
        n_acc    = 0;
        start_inv(base, cnt, stride, sel);
        wait_valid(3000, waited);
        check({tag, "_value"}, 64'(m_output_value), 64'(exp_val));
        check({tag, "_reads"}, 64'(n_acc), 64'(cnt));
        check({tag, "_addrs_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        handshake();
    endtask

    task automatic set_lat(input int a, input int b, input int c, input int d);
        lat_tab[0] = a; lat_tab[1] = b; lat_tab[2] = c; lat_tab[3] = d;
    endtask

    task automatic set_stall(input int a, input int b, input int c, input int d);
        stall_tab[0] = a; stall_tab[1] = b; stall_tab[2] = c; stall_tab[3] = d;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int waited;
        reset          = 1'b1;
        m_src_addr     = '0;
        m_input_count  = '0;
        m_input_stride = '0;
        m_input_select = '0;
        m_valid_in     = 1'b0;
        m_ready_in     = 1'b0;
        src_writeack   = 1'b0;
        set_lat(3, 3, 3, 3);
        set_stall(0, 0, 0, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("rst_ready_out", 64'(m_ready_out), 64'd1);
        check("rst_valid_out", 64'(m_valid_out), 64'd0);
        check("rst_src_read", 64'(src_read), 64'd0);
        check("rst_src_address", 64'(src_address), 64'd0);
        check("rst_output_value", 64'(m_output_value), 64'd0);
        check("tie_src_write", 64'(src_write), 64'd0);
        check("tie_burstcount", 64'(src_burstcount), 64'd1);
        check("tie_byteenable", src_byteenable, 64'hFFFF_FFFF_FFFF_FFFF);
        check("tie_writedata", 64'(|src_writedata), 64'd0);

        // 4 probes, stride 1, fixed latency 3: L = 3 each.
        run_inv("t1_sum", 32'h1000, 4, 1, SEL_SUM, 32'd12);
        run_inv("t1_min", 32'h1000, 4, 1, SEL_MIN, 32'd3);
        run_inv("t1_max", 32'h1000, 4, 1, SEL_MAX, 32'd3);
        run_inv("t1_err", 32'h1000, 4, 1, SEL_ERR, 32'd0);

        // stride 2, latencies 5,2,9 with 2 stall cycles on the last: L = 5,2,11.
        set_lat(5, 2, 9, 9);
        set_stall(0, 0, 2, 0);
        run_inv("t2_min", 32'h2000, 3, 2, SEL_MIN, 32'd2);
        run_inv("t2_max", 32'h2000, 3, 2, SEL_MAX, 32'd11);
        run_inv("t2_sum", 32'h2000, 3, 2, SEL_SUM, 32'd18);
        set_stall(0, 0, 0, 0);

        // X[0] corrupted.
        set_lat(4, 4, 4, 4);
        corrupt_ix = 0;
        run_inv("t3_err", 32'h3000, 2, 1, SEL_ERR, 32'd1);
        run_inv("t3_sum", 32'h3000, 2, 1, SEL_SUM, 32'd8);
        corrupt_ix = -1;

        // count = 0: no reads, result almost immediately.
        cur_base = 32'h5000;
        probe_n  = 0;
        n_acc    = 0;
        start_inv(32'h5000, 0, 1, SEL_MIN);
        wait_valid(10, waited);
        check("t4_valid_latency_ok", 64'(waited <= 1), 64'd1);
        check("t4_min_value", 64'(m_output_value), 64'd0);
        check("t4_no_reads", 64'(n_acc), 64'd0);
        handshake();
        run_inv("t4_max", 32'h5000, 0, 1, SEL_MAX, 32'd0);

        // Backpressure in DONE, with ignored invocation pulses.
        set_lat(7, 7, 7, 7);
        exp_q.push_back(32'h6000);
        cur_base = 32'h6000;
        probe_n  = 0;
        n_acc    = 0;
        start_inv(32'h6000, 1, 1, SEL_MAX);
        wait_valid(100, waited);
        for (int i = 0; i < 10; i++) begin
            if (i == 3 || i == 6) begin
                m_src_addr     = 64'h7000;
                m_input_count  = 32'd2;
                m_input_select = SEL_SUM;
                m_valid_in     = 1'b1;
            end else begin
                m_valid_in     = 1'b0;
            end
            @(negedge clock);
            check("t5_valid_held", 64'(m_valid_out), 64'd1);
            check("t5_value_held", 64'(m_output_value), 64'd7);
            check("t5_busy", 64'(m_ready_out), 64'd0);
        end
        m_valid_in = 1'b0;
        handshake();
        repeat (5) @(negedge clock);
        check("t5_no_extra_reads", 64'(n_acc), 64'd1);
        check("t5_idle_valid", 64'(m_valid_out), 64'd0);
        run_inv("t5_after", 32'h6000, 2, 3, SEL_SUM, 32'd14);

        // Reset during WAIT, then the late response arrives.
        set_lat(20, 20, 20, 20);
        exp_q.push_back(32'h8000);
        cur_base = 32'h8000;
        probe_n  = 0;
        n_acc    = 0;
        start_inv(32'h8000, 1, 1, SEL_SUM);
        repeat (4) @(negedge clock);
        check("t6_in_wait", 64'(src_read), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            check("t6_idle_after_rst", 64'({m_ready_out, m_valid_out, src_read}), 64'b100);
        end
        check("t6_value_zero", 64'(m_output_value), 64'd0);
        exp_q.delete();
        set_lat(3, 3, 3, 3);
        run_inv("t6_recover", 32'h9000, 1, 1, SEL_MAX, 32'd3);

`ifdef READ_SWEEP_TIMEOUT_EN
        // Response never comes: watchdog aborts with all-ones.
        drop_resp = 1;
        run_inv("t7_timeout", 32'hA000, 1, 1, SEL_MIN, 32'hFFFF_FFFF);
        drop_resp = 0;
        run_inv("t7_recover", 32'hB000, 2, 1, SEL_SUM, 32'd6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
